uart_cmd_ctrl: RTL and testbench



---
 rtl/uart_cmd_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// ============================================================================
// Module   : uart_cmd_ctrl
// Purpose  : Frame controller behind the UART byte receiver. Assembles
//            SYNC / OP / LEN / payload / [checksum] frames from one-cycle
//            byte strobes and presents each validated command on a
//            valid/ready handshake. Timed-out, bad-checksum, over-length
//            and overrunning frames raise a one-cycle frame_err with a code.
// Build    : UART_CMD_CHECKSUM_EN - when defined, frames carry a trailing
//            XOR checksum byte (err_code 1 possible). When undefined, the
//            frame ends after the last payload byte (or LEN==0).
// Ports    : clk, rst (async, active-high)
//            rx_valid/rx_data            - byte strobe from the receiver
//            cmd_valid/cmd_ready         - command handshake
//            cmd_op/cmd_len/cmd_payload  - command fields (payload byte i
//                                          on bits [8i+7:8i], unused = 0)
//            frame_err/err_code          - error pulse; 0=timeout,
//                                          1=checksum, 2=length, 3=overrun
//            busy                        - high outside IDLE
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_ctrl #(
    parameter int         MAX_PAYLOAD    = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [7:0]               cmd_op,
    output logic [3:0]               cmd_len,
    output logic [8*MAX_PAYLOAD-1:0] cmd_payload,
    output logic                     frame_err,
    output logic [1:0]               err_code,
    output logic                     busy
);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_OP      = 3'd1;
    localparam logic [2:0] c_S_LEN     = 3'd2;
    localparam logic [2:0] c_S_PAYLOAD = 3'd3;
    localparam logic [2:0] c_S_HOLD    = 3'd5;
`ifdef UART_CMD_CHECKSUM_EN
    localparam logic [2:0] c_S_CSUM    = 3'd4;
    // Where the frame goes once the body (OP/LEN/payload) is complete.
    localparam logic [2:0] c_S_BODY_DONE = c_S_CSUM;
    localparam logic [1:0] c_ERR_CSUM    = 2'd1;
`else
    localparam logic [2:0] c_S_BODY_DONE = c_S_HOLD;
`endif

    localparam logic [1:0] c_ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] c_ERR_LENGTH  = 2'd2;
    localparam logic [1:0] c_ERR_OVERRUN = 2'd3;

    localparam int                 c_TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]         c_MAX_LEN  = 8'(MAX_PAYLOAD);

    logic [2:0]               r_state;
    logic [7:0]               r_cmdOp;
    logic [3:0]               r_cmdLen;
    logic [8*MAX_PAYLOAD-1:0] r_payload;
    logic [3:0]               r_idx;
    logic [c_TMR_W-1:0]       r_timer;
    logic                     r_frameErr;
    logic [1:0]               r_errCode;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]               r_acc;
`endif

    logic [2:0] w_nextState;
    logic       w_errPulse;
    logic [1:0] w_errCode;
    logic       w_startFrame;
    logic       w_loadOp;
    logic       w_loadLen;
    logic       w_loadPay;
    logic       w_midFrame;
    logic       w_timeout;
    logic       w_lastByte;

    // Inter-byte timer only runs while a frame is partially received.
    assign w_midFrame = (r_state == c_S_OP) || (r_state == c_S_LEN) ||
                        (r_state == c_S_PAYLOAD)
`ifdef UART_CMD_CHECKSUM_EN
                        || (r_state == c_S_CSUM)
`endif
                        ;
    // A byte arriving in the expiry cycle wins over the timeout.
    assign w_timeout  = w_midFrame && !rx_valid && (r_timer == c_TMR_LAST);
    assign w_lastByte = (r_idx == (r_cmdLen - 4'd1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState  = r_state;
        w_errPulse   = 1'b0;
        w_errCode    = r_errCode;
        w_startFrame = 1'b0;
        w_loadOp     = 1'b0;
        w_loadLen    = 1'b0;
        w_loadPay    = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    w_startFrame = 1'b1;
                    w_nextState  = c_S_OP;
                end
            end
            c_S_OP: begin
                if (rx_valid) begin
                    w_loadOp    = 1'b1;
                    w_nextState = c_S_LEN;
                end
            end
            c_S_LEN: begin
                if (rx_valid) begin
                    w_loadLen = 1'b1;
                    // Full-byte compare: 0x13 must not alias to length 3.
                    if (rx_data > c_MAX_LEN) begin
                        w_errPulse  = 1'b1;
                        w_errCode   = c_ERR_LENGTH;
                        w_nextState = c_S_IDLE;
                    end else if (rx_data == 8'd0) begin
                        w_nextState = c_S_BODY_DONE;
                    end else begin
                        w_nextState = c_S_PAYLOAD;
                    end
                end
            end
            c_S_PAYLOAD: begin
                if (rx_valid) begin
                    w_loadPay = 1'b1;
                    if (w_lastByte) begin
                        w_nextState = c_S_BODY_DONE;
                    end
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            c_S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == r_acc) begin
                        w_nextState = c_S_HOLD;
                    end else begin
                        w_errPulse  = 1'b1;
                        w_errCode   = c_ERR_CSUM;
                        w_nextState = c_S_IDLE;
                    end
                end
            end
`endif
            c_S_HOLD: begin
                // Bytes arriving while a command is pending are lost.
                if (rx_valid) begin
                    w_errPulse = 1'b1;
                    w_errCode  = c_ERR_OVERRUN;
                end
                if (cmd_ready) begin
                    w_nextState = c_S_IDLE;
                end
            end
            default: begin
                w_nextState = c_S_IDLE;
            end
        endcase

        if (w_timeout) begin
            w_errPulse  = 1'b1;
            w_errCode   = c_ERR_TIMEOUT;
            w_nextState = c_S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmdOp    <= 8'd0;
            r_cmdLen   <= 4'd0;
            r_payload  <= '0;
            r_idx      <= 4'd0;
            r_timer    <= '0;
            r_frameErr <= 1'b0;
            r_errCode  <= 2'd0;
        end else begin
            r_frameErr <= w_errPulse;
            r_errCode  <= w_errCode;

            if (rx_valid || !w_midFrame || w_timeout) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_loadOp) begin
                r_cmdOp <= rx_data;
            end
            if (w_loadLen) begin
                r_cmdLen <= rx_data[3:0];
                r_idx    <= 4'd0;
            end

            if (w_startFrame) begin
                r_payload <= '0;
            end else if (w_loadPay) begin
                r_idx <= r_idx + 4'd1;
                for (int i = 0; i < MAX_PAYLOAD; i++) begin
                    if (r_idx == i[3:0]) begin
                        r_payload[8*i +: 8] <= rx_data;
                    end
                end
            end
        end
    end

`ifdef UART_CMD_CHECKSUM_EN
    // Running XOR over OP, LEN and payload bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= 8'd0;
        end else if (w_startFrame) begin
            r_acc <= 8'd0;
        end else if (w_loadOp || w_loadLen || w_loadPay) begin
            r_acc <= r_acc ^ rx_data;
        end
    end
`endif

    assign cmd_valid   = (r_state == c_S_HOLD);
    assign busy        = (r_state != c_S_IDLE);
    assign cmd_op      = r_cmdOp;
    assign cmd_len     = r_cmdLen;
    assign cmd_payload = r_payload;
    assign frame_err   = r_frameErr;
    assign err_code    = r_errCode;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
// ============================================================================
// Module   : tb_uart_cmd_ctrl
// Purpose  : Self-checking bench for uart_cmd_ctrl. A table of directed
//            frames with hand-computed results, plus sequences for timeout,
//            overrun and asynchronous reset. Checksum bytes are sent only
//            when UART_CMD_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_ctrl;

    localparam int c_MAXP = 8;
    localparam int c_TMO  = 20;

    logic              clk;
    logic              rst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [7:0]        cmd_op;
    logic [3:0]        cmd_len;
    logic [8*c_MAXP-1:0] cmd_payload;
    logic              frame_err;
    logic [1:0]        err_code;
    logic              busy;

    int total = 0;
    int bad   = 0;

    uart_cmd_ctrl #(
        .MAX_PAYLOAD   (c_MAXP),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(c_TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_len    (cmd_len),
        .cmd_payload(cmd_payload),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame bytes are stored left-justified: byte 0 in bits [95:88].
    typedef struct {
        logic [95:0] bytes;
        int          n;
        logic [7:0]  csum;
        bit          hasCsum;
        bit          expValid;
        logic [1:0]  expCode;
        logic [7:0]  expOp;
        logic [3:0]  expLen;
        logic [63:0] expPay;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(input logic [95:0] raw, input int n,
                                   input logic [7:0] cs, input bit hasCs,
                                   input bit v, input logic [1:0] code,
                                   input logic [7:0] op, input logic [3:0] len,
                                   input logic [63:0] pay);
        vec_t t;
        t.bytes    = raw << (8 * (12 - n));
        t.n        = n;
        t.csum     = cs;
        t.hasCsum  = hasCs;
        t.expValid = v;
        t.expCode  = code;
        t.expOp    = op;
        t.expLen   = len;
        t.expPay   = pay;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic sendFrame(input vec_t v);
        for (int k = 0; k < v.n; k++) begin
            sendByte(v.bytes[95 - 8*k -: 8]);
        end
`ifdef UART_CMD_CHECKSUM_EN
        if (v.hasCsum) sendByte(v.csum);
`endif
    endtask

    task automatic applyVec(input int idx, input vec_t v);
        string s;
        cmd_ready = 1'b1;
        sendFrame(v);
        s = $sformatf("vec%0d", idx);
        if (v.expValid) begin
            check({s, " cmd_valid"}, cmd_valid, 1);
            check({s, " frame_err"}, frame_err, 0);
            check({s, " cmd_op"}, cmd_op, v.expOp);
            check({s, " cmd_len"}, cmd_len, v.expLen);
            check({s, " payload"}, cmd_payload, v.expPay);
            tick();
            check({s, " cmd_valid drop"}, cmd_valid, 0);
            check({s, " busy after"}, busy, 0);
        end else begin
            check({s, " frame_err"}, frame_err, 1);
            check({s, " err_code"}, err_code, v.expCode);
            check({s, " cmd_valid"}, cmd_valid, 0);
            check({s, " busy"}, busy, 0);
            tick();
            check({s, " err pulse width"}, frame_err, 0);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int firstAt;
        int errCnt;
        logic [1:0] seenCode;
        bit flag;

        rst       = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b1;

        // --- table ---
        vecs.push_back(mkVec(96'hA510023344, 5, 8'h65, 1, 1, 2'd0, 8'h10, 4'd2, 64'h4433));
        vecs.push_back(mkVec(96'h007EA52009, 5, 8'h00, 0, 0, 2'd2, 8'h00, 4'd0, 64'h0));
        vecs.push_back(mkVec(96'hA50100,     3, 8'h01, 1, 1, 2'd0, 8'h01, 4'd0, 64'h0));
        vecs.push_back(mkVec(96'hA507080102030405060708, 11, 8'h07, 1, 1, 2'd0,
                             8'h07, 4'd8, 64'h0807060504030201));
        vecs.push_back(mkVec(96'hA52209,     3, 8'h00, 0, 0, 2'd2, 8'h00, 4'd0, 64'h0));
        vecs.push_back(mkVec(96'hA522F3,     3, 8'h00, 0, 0, 2'd2, 8'h00, 4'd0, 64'h0));
        vecs.push_back(mkVec(96'hA5A501A5,   4, 8'h01, 1, 1, 2'd0, 8'hA5, 4'd1, 64'hA5));
`ifdef UART_CMD_CHECKSUM_EN
        vecs.push_back(mkVec(96'hA510023344, 5, 8'h66, 1, 0, 2'd1, 8'h00, 4'd0, 64'h0));
`endif

        // --- reset state ---
        tick();
        tick();
        check("reset cmd_valid", cmd_valid, 0);
        check("reset frame_err", frame_err, 0);
        check("reset busy", busy, 0);
        check("reset cmd_op", cmd_op, 0);
        check("reset cmd_len", cmd_len, 0);
        check("reset payload", cmd_payload, 0);
        check("reset err_code", err_code, 0);
        rst = 1'b0;
        tick();

        // --- table-driven frames ---
        for (int i = 0; i < vecs.size(); i++) begin
            applyVec(i, vecs[i]);
        end

        // --- timeout mid-payload ---
        sendByte(8'hA5); sendByte(8'h10); sendByte(8'h02); sendByte(8'h33);
        firstAt  = -1;
        errCnt   = 0;
        seenCode = 2'd3;
        flag     = 1'b0;
        for (int c = 1; c <= 3 * c_TMO; c++) begin
            tick();
            if (frame_err) begin
                errCnt++;
                if (firstAt < 0) begin
                    firstAt  = c;
                    seenCode = err_code;
                    flag     = busy;
                end
            end
        end
        check("timeout latency", firstAt, c_TMO);
        check("timeout pulse count", errCnt, 1);
        check("timeout err_code", seenCode, 0);
        check("timeout busy", flag, 0);
        applyVec(100, vecs[0]);

        // --- byte arriving in the expiry cycle wins ---
        sendByte(8'hA5);
        flag = 1'b0;
        for (int c = 0; c < c_TMO - 1; c++) begin
            tick();
            if (frame_err) flag = 1'b1;
        end
        sendByte(8'h10);
        check("expiry early err", flag, 0);
        check("expiry byte wins err", frame_err, 0);
        check("expiry byte wins busy", busy, 1);
        sendByte(8'h00);
`ifdef UART_CMD_CHECKSUM_EN
        sendByte(8'h10);
`endif
        check("expiry frame valid", cmd_valid, 1);
        check("expiry frame op", cmd_op, 8'h10);
        check("expiry frame len", cmd_len, 0);
        tick();

        // --- overrun while holding ---
        cmd_ready = 1'b0;
        sendFrame(vecs[0]);
        check("ovr hold valid", cmd_valid, 1);
        sendByte(8'h55);
        check("ovr frame_err", frame_err, 1);
        check("ovr err_code", err_code, 3);
        check("ovr still valid", cmd_valid, 1);
        flag = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!cmd_valid || frame_err || cmd_op !== 8'h10 || cmd_len !== 4'd2 ||
                cmd_payload !== 64'h4433 || err_code !== 2'd3 || !busy) flag = 1'b1;
        end
        check("ovr outputs stable", flag, 0);
        cmd_ready = 1'b1;
        tick();
        check("ovr handshake drop", cmd_valid, 0);
        check("ovr handshake idle", busy, 0);

        // --- overrun in the handshake cycle ---
        cmd_ready = 1'b0;
        sendFrame(vecs[2]);
        cmd_ready = 1'b1;
        sendByte(8'h55);
        check("ovr+hs frame_err", frame_err, 1);
        check("ovr+hs err_code", err_code, 3);
        check("ovr+hs cmd_valid", cmd_valid, 0);
        check("ovr+hs busy", busy, 0);
        tick();

        // --- asynchronous reset mid-payload ---
        sendByte(8'hA5); sendByte(8'h10); sendByte(8'h02); sendByte(8'h33);
        check("pre-reset busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst busy", busy, 0);
        check("async rst cmd_op", cmd_op, 0);
        check("async rst cmd_len", cmd_len, 0);
        check("async rst payload", cmd_payload, 0);
        check("async rst err_code", err_code, 0);
        check("async rst cmd_valid", cmd_valid, 0);
        check("async rst frame_err", frame_err, 0);
        #2;
        rst = 1'b0;
        tick();
        applyVec(200, vecs[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
